// File: rtl/reg_decr_stream_pkg.sv
// Shared types and default sizes for the registered stream decrementer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package decr_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    // Occupancy of the two-entry output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_st_t;

endpackage

// File: rtl/reg_decr_stream_skid_buf.sv
// Two-entry valid/ready skid buffer: a main output register plus one overflow register.
// Latency: 1 cycle from accept to out_val when the main register is empty or retiring.
// Backpressure: in_rdy is registered (!full), so out_rdy never reaches in_rdy combinationally.
module skid_buf
    import decr_pkg::*;
#(
    parameter int P_W = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_val,
    output logic           in_rdy,
    input  logic [P_W-1:0] in_data,
    output logic           out_val,
    input  logic           out_rdy,
    output logic [P_W-1:0] out_data
);

    buf_st_t        st_q, st_d;
    logic [P_W-1:0] main_q, main_d;
    logic [P_W-1:0] skid_q, skid_d;
    logic           in_rdy_q;
    logic           acc;
    logic           ret;

    assign in_rdy   = in_rdy_q;
    assign out_val  = (st_q != EMPTY);
    assign out_data = main_q;
    assign acc      = in_val && in_rdy_q;
    assign ret      = (st_q != EMPTY) && out_rdy;

    // Next occupancy and register contents; the skid entry always drains into main first.
    always_comb begin
        st_d   = st_q;
        main_d = main_q;
        skid_d = skid_q;
        case (st_q)
            EMPTY: begin
                if (acc) begin
                    main_d = in_data;
                    st_d   = ONE;
                end
            end
            ONE: begin
                case ({acc, ret})
                    2'b11: main_d = in_data;
                    2'b10: begin
                        skid_d = in_data;
                        st_d   = FULL;
                    end
                    2'b01: st_d = EMPTY;
                    default: ;
                endcase
            end
            FULL: begin
                if (ret) begin
                    main_d = skid_q;
                    st_d   = ONE;
                end
            end
            default: st_d = EMPTY;
        endcase
    end

    // State registers; ready is held low through reset and derived from the next occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q     <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            in_rdy_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            in_rdy_q <= (st_d != FULL);
        end
    end

endmodule

// File: rtl/reg_decr_stream.sv
// Stream decrementer: each accepted word leaves as in_data-1 with a borrow flag; counts borrows.
// Latency: 1 cycle through the skid buffer; 1 word/cycle while out_rdy stays high.
// Backpressure: registered in_rdy from the skid buffer; holds outputs stable while stalled.
module reg_decr_stream
    import decr_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SATURATE = 0,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_borrow,
    output logic [CNT_W-1:0] borrow_cnt
);

    logic             is_zero;
    logic [WIDTH-1:0] dec_data;
    logic [WIDTH:0]   pay_in;
    logic [WIDTH:0]   pay_out;
    logic             acc;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign is_zero = (in_data == '0);
    assign pay_in  = {is_zero, dec_data};
    assign acc     = in_val && in_rdy;

    // Decrement, with zero either wrapping to all-ones or clamping at zero.
    always_comb begin
        dec_data = in_data - WIDTH'(1);
        if (is_zero) begin
            dec_data = (SATURATE != 0) ? '0 : '1;
        end
    end

    skid_buf #(
        .P_W (WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_data  (pay_in),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (pay_out)
    );

    assign out_borrow = pay_out[WIDTH];
    assign out_data   = pay_out[WIDTH-1:0];
    assign borrow_cnt = cnt_q;

    // Borrow counter advances on the accept edge of a zero word and sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (acc && is_zero && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_reg_decr_stream.sv
// Bench for reg_decr_stream: three instances (wrap, saturate, 2-bit counter) on shared inputs.
// Latency: checks 1-cycle accept-to-output against a queue-based reference model.
// Backpressure: random out_rdy stalls; model predicts in_rdy from its own occupancy.
module tb_reg_decr_stream;

    logic       clk;
    logic       rst;
    logic       in_val;
    logic       out_rdy;
    logic [7:0] in_data;

    logic       in_rdy_w, out_val_w, borrow_w;
    logic [7:0] data_w;
    logic [15:0] cnt_w;

    logic       in_rdy_s, out_val_s, borrow_s;
    logic [7:0] data_s;
    logic [15:0] cnt_s;

    logic       in_rdy_c, out_val_c, borrow_c;
    logic [7:0] data_c;
    logic [1:0] cnt_c;

    int errors = 0;
    int checks = 0;

    // Reference model: words in flight (raw input values), borrow counts, ready-after-reset flag.
    int unsigned q[$];
    int unsigned cnt16 = 0;
    int unsigned cnt2  = 0;
    bit          rdy_ok = 0;
    int unsigned accepted = 0;

    reg_decr_stream #(.WIDTH(8), .SATURATE(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy_w), .in_data(in_data),
        .out_val(out_val_w), .out_rdy(out_rdy), .out_data(data_w), .out_borrow(borrow_w),
        .borrow_cnt(cnt_w)
    );

    reg_decr_stream #(.WIDTH(8), .SATURATE(1), .CNT_W(16)) dut_s (
        .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy_s), .in_data(in_data),
        .out_val(out_val_s), .out_rdy(out_rdy), .out_data(data_s), .out_borrow(borrow_s),
        .borrow_cnt(cnt_s)
    );

    reg_decr_stream #(.WIDTH(8), .SATURATE(0), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy_c), .in_data(in_data),
        .out_val(out_val_c), .out_rdy(out_rdy), .out_data(data_c), .out_borrow(borrow_c),
        .borrow_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_rdy();
        return rdy_ok && (q.size() < 2);
    endfunction

    function automatic logic [7:0] exp_wrap(input int unsigned x);
        return (x == 0) ? 8'hFF : 8'(x - 1);
    endfunction

    function automatic logic [7:0] exp_sat(input int unsigned x);
        return (x == 0) ? 8'h00 : 8'(x - 1);
    endfunction

    // Advance one clock, updating the model from the inputs as they stood before the edge.
    task automatic tick();
        bit          acc;
        bit          ret;
        int unsigned d;
        acc = rst && in_val && exp_rdy();
        ret = rst && out_rdy && (q.size() > 0);
        d   = in_data;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            cnt16  = 0;
            cnt2   = 0;
            rdy_ok = 0;
        end else begin
            if (ret) void'(q.pop_front());
            if (acc) begin
                q.push_back(d);
                accepted++;
                if (d == 0) begin
                    if (cnt16 < 65535) cnt16++;
                    if (cnt2 < 3) cnt2++;
                end
            end
            rdy_ok = 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; in_val = 1'b0; out_rdy = 1'b0; in_data = 8'h00;
        repeat (10) tick();
        checks++; if (out_val_w !== 1'b0) begin errors++; $display("FAIL reset_out_val got=%b exp=0", out_val_w); end
        checks++; if (data_w !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", data_w); end
        checks++; if (borrow_w !== 1'b0) begin errors++; $display("FAIL reset_out_borrow got=%b exp=0", borrow_w); end
        checks++; if (cnt_w !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt_w); end
        checks++; if (in_rdy_w !== 1'b0) begin errors++; $display("FAIL reset_in_rdy_low got=%b exp=0", in_rdy_w); end
        rst = 1'b1;
        tick();
        checks++; if (in_rdy_w !== 1'b1) begin errors++; $display("FAIL release_in_rdy got=%b exp=1", in_rdy_w); end
        checks++; if (out_val_w !== 1'b0) begin errors++; $display("FAIL release_out_val got=%b exp=0", out_val_w); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ins [3];
        logic [7:0] outs[3];
        ins  = '{8'h01, 8'h14, 8'h28};
        outs = '{8'h00, 8'h13, 8'h27};
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_val = 1'b1; in_data = ins[i];
            tick();
            checks++; if (out_val_w !== 1'b1 || data_w !== outs[i])
                begin errors++; $display("FAIL b2b_word%0d got val=%b data=%h exp val=1 data=%h", i, out_val_w, data_w, outs[i]); end
            checks++; if (borrow_w !== 1'b0) begin errors++; $display("FAIL b2b_borrow%0d got=%b exp=0", i, borrow_w); end
            checks++; if (in_rdy_w !== 1'b1) begin errors++; $display("FAIL b2b_in_rdy%0d got=%b exp=1", i, in_rdy_w); end
        end
        in_val = 1'b0;
        tick();
        checks++; if (out_val_w !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_val_w); end
    endtask

    task automatic test_borrow();
        out_rdy = 1'b1; in_val = 1'b1; in_data = 8'h00;
        tick();
        in_val = 1'b0;
        checks++; if (data_w !== 8'hFF || borrow_w !== 1'b1)
            begin errors++; $display("FAIL borrow_wrap got data=%h b=%b exp data=ff b=1", data_w, borrow_w); end
        checks++; if (data_s !== 8'h00 || borrow_s !== 1'b1)
            begin errors++; $display("FAIL borrow_sat got data=%h b=%b exp data=00 b=1", data_s, borrow_s); end
        checks++; if (cnt_w !== 16'd1) begin errors++; $display("FAIL borrow_cnt got=%0d exp=1", cnt_w); end
        tick();
    endtask

    task automatic test_stall();
        out_rdy = 1'b0; in_val = 1'b1; in_data = 8'h05;
        tick();
        checks++; if (out_val_w !== 1'b1 || data_w !== 8'h04 || in_rdy_w !== 1'b1)
            begin errors++; $display("FAIL stall_first got val=%b data=%h rdy=%b exp 1/04/1", out_val_w, data_w, in_rdy_w); end
        in_data = 8'h06;
        tick();
        checks++; if (in_rdy_w !== 1'b0) begin errors++; $display("FAIL stall_full_rdy got=%b exp=0", in_rdy_w); end
        in_data = 8'h07;
        repeat (3) begin
            tick();
            checks++; if (out_val_w !== 1'b1 || data_w !== 8'h04 || in_rdy_w !== 1'b0)
                begin errors++; $display("FAIL stall_hold got val=%b data=%h rdy=%b exp 1/04/0", out_val_w, data_w, in_rdy_w); end
        end
        out_rdy = 1'b1;
        tick();
        checks++; if (data_w !== 8'h05 || in_rdy_w !== 1'b1)
            begin errors++; $display("FAIL stall_second got data=%h rdy=%b exp 05/1", data_w, in_rdy_w); end
        tick();
        in_val = 1'b0;
        checks++; if (out_val_w !== 1'b1 || data_w !== 8'h06)
            begin errors++; $display("FAIL stall_third got val=%b data=%h exp 1/06", out_val_w, data_w); end
        tick();
        checks++; if (out_val_w !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b exp=0", out_val_w); end
    endtask

    task automatic test_random();
        int unsigned base;
        int          cyc;
        int unsigned x;
        base = accepted;
        cyc  = 0;
        while ((accepted < base + 1000) && (cyc < 20000)) begin
            in_val  = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            in_data = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            tick();
            cyc++;
            checks++; if (out_val_w !== (q.size() > 0))
                begin errors++; $display("FAIL rnd_out_val cyc=%0d got=%b exp=%b", cyc, out_val_w, q.size() > 0); end
            checks++; if (in_rdy_w !== exp_rdy())
                begin errors++; $display("FAIL rnd_in_rdy cyc=%0d got=%b exp=%b", cyc, in_rdy_w, exp_rdy()); end
            if (q.size() > 0) begin
                x = q[0];
                checks++; if (data_w !== exp_wrap(x) || borrow_w !== (x == 0))
                    begin errors++; $display("FAIL rnd_wrap cyc=%0d got=%h/%b exp=%h/%b", cyc, data_w, borrow_w, exp_wrap(x), x == 0); end
                checks++; if (data_s !== exp_sat(x))
                    begin errors++; $display("FAIL rnd_sat cyc=%0d got=%h exp=%h", cyc, data_s, exp_sat(x)); end
            end
            checks++; if (cnt_w !== 16'(cnt16) || cnt_c !== 2'(cnt2))
                begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, cnt_w, cnt_c, cnt16, cnt2); end
        end
        checks++; if (accepted < base + 1000)
            begin errors++; $display("FAIL rnd_timeout accepted=%0d exp=%0d", accepted - base, 1000); end
        in_val = 1'b0; out_rdy = 1'b1;
        repeat (3) tick();
        checks++; if (out_val_w !== 1'b0 || q.size() != 0)
            begin errors++; $display("FAIL rnd_drain got val=%b left=%0d exp 0/0", out_val_w, q.size()); end
    endtask

    task automatic test_reset_full();
        out_rdy = 1'b0; in_val = 1'b1; in_data = 8'h21;
        tick();
        in_data = 8'h22;
        tick();
        checks++; if (in_rdy_w !== 1'b0) begin errors++; $display("FAIL rf_full got rdy=%b exp=0", in_rdy_w); end
        rst = 1'b0; in_val = 1'b0;
        tick();
        checks++; if (out_val_w !== 1'b0 || in_rdy_w !== 1'b0)
            begin errors++; $display("FAIL rf_reset got val=%b rdy=%b exp 0/0", out_val_w, in_rdy_w); end
        rst = 1'b1;
        tick();
        checks++; if (out_val_w !== 1'b0 || in_rdy_w !== 1'b1)
            begin errors++; $display("FAIL rf_release got val=%b rdy=%b exp 0/1", out_val_w, in_rdy_w); end
        in_val = 1'b1; in_data = 8'h10; out_rdy = 1'b1;
        tick();
        in_val = 1'b0;
        checks++; if (out_val_w !== 1'b1 || data_w !== 8'h0F)
            begin errors++; $display("FAIL rf_word got val=%b data=%h exp 1/0f", out_val_w, data_w); end
        tick();
        checks++; if (out_val_w !== 1'b0) begin errors++; $display("FAIL rf_only_one got=%b exp=0", out_val_w); end
    endtask

    task automatic test_cnt_sat();
        int unsigned n;
        rst = 1'b0; in_val = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        out_rdy = 1'b1; in_val = 1'b1; in_data = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n = (i > 3) ? 3 : i;
            checks++; if (cnt_c !== 2'(n))
                begin errors++; $display("FAIL cnt_sat word%0d got=%0d exp=%0d", i, cnt_c, n); end
        end
        in_val = 1'b0;
        tick();
        checks++; if (cnt_c !== 2'b11 || cnt_w !== 16'd5)
            begin errors++; $display("FAIL cnt_final got=%0d/%0d exp=3/5", cnt_c, cnt_w); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_borrow();
        test_stall();
        test_random();
        test_reset_full();
        test_cnt_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
